// File: rtl/stream_merge_4to1_pkg.sv
// stream_merge_4to1_pkg: channel encoding and FSM states, shared with the 1-to-4 decoder side.
package stream_merge_4to1_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W = 2;
    localparam logic [SEL_W-1:0] RR_RESET = 2'b11;
    typedef enum logic {IDLE, HOLD} state_t;
    function automatic logic [SEL_W-1:0] onehot_idx(input logic [NUM_CH-1:0] v);
        onehot_idx = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (v[i]) onehot_idx = SEL_W'(i);
    endfunction
endpackage

// File: rtl/stream_merge_4to1_if.sv
// stream_merge_4to1_if: four source channels in, one tagged stream out.
interface stream_merge_4to1_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] in0, in1, in2, in3;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [WIDTH-1:0] out;
    logic [1:0] out_sel;
    logic out_valid;
    logic out_ready;
    modport slave (input in0, in1, in2, in3, in_valid, out_ready,
                   output in_ready, out, out_sel, out_valid);
    modport master (output in0, in1, in2, in3, in_valid, out_ready,
                    input in_ready, out, out_sel, out_valid);
endinterface

// File: rtl/stream_merge_4to1_rr_arbiter.sv
// rr_arbiter_4: combinational round-robin arbiter with burst-hold override for the current owner.
module rr_arbiter_4
    import stream_merge_4to1_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              hold_en,
    input  logic [SEL_W-1:0]  owner,
    output logic [NUM_CH-1:0] grant
);
    logic [SEL_W-1:0] idx;
    // Scan farthest-first so the nearest requester after ptr wins the last write.
    always_comb begin
        grant = '0;
        idx = ptr;
        if (hold_en && req[owner])
            grant = NUM_CH'(1) << owner;
        else
            for (int k = NUM_CH; k >= 1; k--) begin
                idx = ptr + SEL_W'(k);
                if (req[idx]) grant = NUM_CH'(1) << idx;
            end
    end
endmodule

// File: rtl/stream_merge_4to1.sv
// stream_merge_4to1: round-robin 4-to-1 merge with burst hold and a registered, channel-tagged output.
module stream_merge_4to1
    import stream_merge_4to1_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BURST_LEN = 1
) (
    input logic clk,
    input logic rst_n,
    stream_merge_4to1_if.slave bus
);
    logic [WIDTH-1:0] data [NUM_CH];
    state_t state;
    logic [SEL_W-1:0] rr_ptr, owner, gsel;
    logic [3:0] beat_cnt;
    logic [NUM_CH-1:0] grant;
    logic load, hold_en;
    assign data[0] = bus.in0;
    assign data[1] = bus.in1;
    assign data[2] = bus.in2;
    assign data[3] = bus.in3;
    assign load = ~bus.out_valid | bus.out_ready;
    assign hold_en = state == HOLD && beat_cnt < 4'(BURST_LEN);
    rr_arbiter_4 u_arb (
        .req(bus.in_valid),
        .ptr(rr_ptr),
        .hold_en(hold_en),
        .owner(owner),
        .grant(grant)
    );
    assign bus.in_ready = load ? grant : '0;
    assign gsel = onehot_idx(grant);
    // The arbiter only returns none when nothing is valid, so an empty grant under load means go idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out <= '0;
            bus.out_sel <= '0;
            bus.out_valid <= 1'b0;
            rr_ptr <= RR_RESET;
            owner <= '0;
            beat_cnt <= '0;
            state <= IDLE;
        end else if (load) begin
            if (|grant) begin
                bus.out <= data[gsel];
                bus.out_sel <= gsel;
                bus.out_valid <= 1'b1;
                state <= HOLD;
                if (state == HOLD && gsel == owner) begin
                    beat_cnt <= beat_cnt < 4'(BURST_LEN) ? beat_cnt + 4'd1 : beat_cnt;
                end else begin
                    owner <= gsel;
                    beat_cnt <= 4'd1;
                    rr_ptr <= gsel;
                end
            end else begin
                bus.out_valid <= 1'b0;
                beat_cnt <= '0;
                state <= IDLE;
            end
        end
    end
endmodule

// File: doc/stream_merge_4to1.md
Name: stream_merge_4to1

Overview:
- Four-to-one merge: the return direction of the 1-to-4 channel decoder.
- Collects 8-bit words from four independent source channels onto one output stream.
- Round-robin arbitration with optional burst hold; output-side valid/ready handshake.
- Tags every output word with its source channel, so downstream logic can demultiplex again.

Parameters:
- WIDTH, 8, data width of each input and of the output.
- BURST_LEN, 1, maximum consecutive beats a granted channel may keep the grant (1..15).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in0, in1, in2, in3  input  WIDTH each  source data.
- in_valid  input  4  bit i = channel i holds a word.
- in_ready  output  4  bit i = channel i word accepted this cycle.
- out  output  WIDTH  registered merged data.
- out_sel  output  2  source channel of the current out word.
- out_valid  output  1  out/out_sel hold a word.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Reset state: out=0, out_sel=0, out_valid=0, rr_ptr=2'b11 (channel 0 highest priority first), owner=0, beat_cnt=0, FSM=IDLE.
  - Asserting rst_n low forces these values immediately, regardless of clk.
- Load condition: load = ~out_valid | out_ready.
  - Output register is full-throughput: 1 word per cycle under no backpressure.
- Grant (combinational):
  - If load=0, grant=none.
  - Else, if FSM=HOLD, in_valid[owner]=1 and beat_cnt<BURST_LEN, grant=owner.
  - Else, grant is the first valid channel searching rr_ptr+1, rr_ptr+2, ... modulo 4.
  - If no channel is valid, grant=none.
- in_ready = one-hot of grant, 0 if none.
  - in_ready depends on in_valid; sources must not wait for in_ready before asserting in_valid.
  - A source must hold its data stable while valid and not ready.
- Transfer on channel g (in_valid[g]&in_ready[g]):
  - Next cycle: out=in_g, out_sel=g, out_valid=1.
  - Latency: 1 cycle from input handshake to out_valid.
- If load=1 and grant=none: out_valid<=0 next cycle; out and out_sel keep their last values.
- Backpressure: while out_valid=1 and out_ready=0:
  - out and out_sel stay stable.
  - in_ready=0.
  - FSM, owner, beat_cnt and rr_ptr are unchanged.
- FSM:
  - IDLE -> HOLD on any transfer: owner=g, beat_cnt=1, rr_ptr=g.
  - HOLD, transfer from owner: beat_cnt+1.
  - HOLD, transfer from another channel h: owner=h, beat_cnt=1, rr_ptr=h. This happens when owner dropped valid or beat_cnt reached BURST_LEN.
  - HOLD -> IDLE when load=1 and no channel is valid; owner is kept, beat_cnt=0.
  - beat_cnt saturates at BURST_LEN; it never wraps.
- BURST_LEN=1: pure round robin, no channel gets two consecutive grants while another channel is valid.
- Wrap-around: rr search from channel 3 continues to 0.
- Fairness bound: a continuously valid channel waits at most 3*BURST_LEN transfers.
- Simultaneous out_ready and new grant in the same cycle: old word is consumed and the new word loads; no bubble.
- Reset mid-operation: any pending word is dropped, out_valid=0; the first grant after reset goes to the lowest-index valid channel.

Decomposition:
- Shared package:
  - NUM_CH=4, SEL_W=2.
  - RR_RESET=2'b11.
  - FSM state enum {IDLE, HOLD}.
  - This package is shared with the decoder side so channel encoding matches.
- Sub-module rr_arbiter_4:
  - Purely combinational.
  - Inputs: req[3:0], ptr[1:0], hold_en, owner.
  - Output: one-hot grant.
  - Top level holds all registers and the FSM.

Test Plan:
- Reset then in_valid=4'b0101, in0=8'hA0, in2=8'hA2, out_ready=1, BURST_LEN=1 -> out sequence A0(sel0), A2(sel2), A0, A2; first out_valid one cycle after first in_ready[0].
- All four valid with in_i=8'h10+i, out_ready=1, BURST_LEN=1 -> sel order 0,1,2,3,0,1, one word per cycle, no bubbles.
- out_ready held 0 for 5 cycles with word 8'h55 in output -> out=8'h55 stable, in_ready=4'b0000 throughout; one cycle after out_ready=1 the next word appears.
- BURST_LEN=3, channels 1 and 3 always valid -> sel 1,1,1,3,3,3,1; channel 1 drops valid after 2 beats -> grant moves to 3 next cycle, beat_cnt=1.
- in_valid goes to 0 with out_ready=1 -> out_valid falls the next cycle, out retains last data, FSM=IDLE.
- rst_n pulsed low between clock edges while out_valid=1 -> out_valid=0 and out=0 immediately; after release with in_valid=4'b1111 the first sel is 0.
